// File: rtl/div_scheduler.sv
// div_scheduler: round-robin front end sharing one free-running iterative divider; option DIV_SCHED_ZERO_CHECK_EN.
// Latency: HOLD_CYC+1 edges from handshake to rsp_valid (zero divisor with the option: rsp_valid right after the grant edge).
// Backpressure: one-hot req_ready only while IDLE; losers keep waiting; the response pulse cannot be stalled.
module div_scheduler #(
  parameter int N        = 32,
  parameter int REQ      = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ-1:0]   req_valid,
  output logic [REQ-1:0]   req_ready,
  input  logic [REQ*N-1:0] req_divident,
  input  logic [REQ*N-1:0] req_divider,
  output logic [N-1:0]     div_divident,
  output logic [N-1:0]     div_divider,
  input  logic [N-1:0]     div_quotient,
  input  logic [N-1:0]     div_reminder,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic [N-1:0]     rsp_quotient,
  output logic [N-1:0]     rsp_reminder,
  output logic             rsp_err,
  output logic             busy
);
  localparam int CNT_W = $clog2(HOLD_CYC + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, gnt_idx, cur_id;
  logic             gnt_found, hs, zero_div, capture;
  logic [CNT_W-1:0] hold_cnt;
  logic [N-1:0]     gnt_divident, gnt_divider;

  // Scan requesters starting at rr_ptr; the outer loop sets the priority order.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < REQ; k++) begin
      for (int j = 0; j < REQ; j++) begin
        if (!gnt_found && req_valid[j] && (j == (int'(rr_ptr) + k) % REQ)) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    gnt_divident = '0;
    gnt_divider  = '0;
    for (int j = 0; j < REQ; j++) begin
      if (gnt_idx == ID_W'(j)) begin
        gnt_divident = req_divident[j*N +: N];
        gnt_divider  = req_divider[j*N +: N];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign hs        = (state == IDLE) && gnt_found;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef DIV_SCHED_ZERO_CHECK_EN
  assign zero_div = (gnt_divider == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (hs) state_nxt = zero_div ? RESP : HOLD;
      HOLD: begin
        if (hold_cnt == CNT_W'(HOLD_CYC)) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      cur_id       <= '0;
      hold_cnt     <= '0;
      div_divident <= '0;
      div_divider  <= '0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
      rsp_reminder <= '0;
    end else begin
      if (hs) begin
        rr_ptr   <= (gnt_idx == ID_W'(REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cur_id   <= gnt_idx;
        hold_cnt <= '0;
        // A rejected zero divisor leaves the divider inputs untouched.
        if (!zero_div) begin
          div_divident <= gnt_divident;
          div_divider  <= gnt_divider;
        end
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (capture) begin
        rsp_id       <= cur_id;
        rsp_quotient <= div_quotient;
        rsp_reminder <= div_reminder;
      end else if (hs && zero_div) begin
        rsp_id       <= gnt_idx;
        rsp_quotient <= '1;
        rsp_reminder <= gnt_divident;
      end
    end
  end

`ifdef DIV_SCHED_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_err <= 1'b0;
    else if (capture)        rsp_err <= 1'b0;
    else if (hs && zero_div) rsp_err <= 1'b1;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler with a free-running 32-cycle-frame divider model whose phase drifts against requests.
// Expected grant order, results and timing come from a round-robin list model and plain integer division.
module tb_div_scheduler;
  localparam int N        = 32;
  localparam int REQ      = 4;
  localparam int ID_W     = 2;
  localparam int HOLD_CYC = 64;
  localparam int FRAME    = 32;

  typedef struct { int id; int edge_n; } hs_t;
  typedef struct { int id; logic [N-1:0] quo; logic [N-1:0] rem; logic err; int edge_n; } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [REQ-1:0]   req_valid = '0;
  logic [REQ-1:0]   req_ready;
  logic [REQ*N-1:0] req_divident = '0;
  logic [REQ*N-1:0] req_divider = '0;
  logic [N-1:0]     div_divident, div_divider;
  logic [N-1:0]     div_quotient = '0;
  logic [N-1:0]     div_reminder = '0;
  logic             rsp_valid, rsp_err, busy;
  logic [ID_W-1:0]  rsp_id;
  logic [N-1:0]     rsp_quotient, rsp_reminder;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_cnt = 0;
  int model_ptr = 0;
  hs_t  hs_q[$];
  rsp_t rsp_q[$];
  int   exp_q[$];
  logic [N-1:0] op_a [REQ];
  logic [N-1:0] op_b [REQ];
  logic [N-1:0] samp_a = '0;
  logic [N-1:0] samp_b = '0;

  div_scheduler #(.N(N), .REQ(REQ), .ID_W(ID_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_divident(req_divident), .req_divider(req_divider),
    .div_divident(div_divident), .div_divider(div_divider),
    .div_quotient(div_quotient), .div_reminder(div_reminder),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_reminder(rsp_reminder),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  // Divider: samples operands at each frame start, publishes that result one frame later.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    frame_cnt <= (frame_cnt + 1) % FRAME;
    if (frame_cnt == 0) begin
      div_quotient <= ref_q(samp_a, samp_b);
      div_reminder <= ref_r(samp_a, samp_b);
      samp_a       <= div_divident;
      samp_b       <= div_divider;
    end
  end

  // Handshakes are logged against the upcoming edge, responses against the edge just passed.
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < REQ; i++)
      if (req_valid[i] && req_ready[i]) hs_q.push_back('{id: i, edge_n: cyc + 1});
    if (rsp_valid)
      rsp_q.push_back('{id: int'(rsp_id), quo: rsp_quotient, rem: rsp_reminder, err: rsp_err, edge_n: cyc});
  end

  task automatic set_ops(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    op_a[id] = a;
    op_b[id] = b;
    req_divident[id*N +: N] = a;
    req_divider[id*N +: N]  = b;
  endtask

  task automatic model_grants(input logic [REQ-1:0] mask);
    logic [REQ-1:0] pend;
    int c;
    pend = mask;
    exp_q.delete();
    while (pend != '0) begin
      for (int k = 0; k < REQ; k++) begin
        c = (model_ptr + k) % REQ;
        if (pend[c]) begin
          exp_q.push_back(c);
          pend[c] = 1'b0;
          model_ptr = (c + 1) % REQ;
          break;
        end
      end
    end
  endtask

  task automatic serve(input int n, input int budget, input logic [REQ-1:0] keep, output bit ok);
    int done;
    done = 0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      while (done < hs_q.size()) begin
        if (!keep[hs_q[done].id]) req_valid[hs_q[done].id] = 1'b0;
        done++;
      end
      if (rsp_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_one(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                         output bit ok, output rsp_t r, output int lat);
    hs_q.delete();
    rsp_q.delete();
    set_ops(id, a, b);
    req_valid[id] = 1'b1;
    serve(1, 4 * HOLD_CYC, '0, ok);
    r   = '{id: -1, quo: '0, rem: '0, err: 1'b0, edge_n: 0};
    lat = -1;
    if (ok && hs_q.size() == 1 && rsp_q.size() == 1) begin
      r   = rsp_q[0];
      lat = r.edge_n - hs_q[0].edge_n;
    end else begin
      ok = 1'b0;
    end
    model_ptr = (id + 1) % REQ;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, busy, rsp_err, req_ready} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {rsp_valid, busy, rsp_err, req_ready});
    end
    checks++;
    if ({div_divident, div_divider} !== '0) begin
      errors++; $display("FAIL reset_div_ops: got %h/%h want 0/0", div_divident, div_divider);
    end
    checks++;
    if ({rsp_id, rsp_quotient, rsp_reminder} !== '0) begin
      errors++; $display("FAIL reset_rsp: got id=%0d q=%h r=%h want 0", rsp_id, rsp_quotient, rsp_reminder);
    end
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; rsp_t r; int lat;
    for (int ph = 0; ph < FRAME; ph++) begin
      @(negedge clk);
      while (frame_cnt != ph) @(negedge clk);
      run_one(1, 32'd100, 32'd7, ok, r, lat);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_ph%0d_resp: got none want one response", ph); end
      checks++;
      if (r.id !== 1 || r.quo !== 32'd14 || r.rem !== 32'd2 || r.err !== 1'b0) begin
        errors++; $display("FAIL single_ph%0d_data: got id=%0d q=%0d r=%0d e=%b want id=1 q=14 r=2 e=0",
                           ph, r.id, r.quo, r.rem, r.err);
      end
      checks++;
      if (lat !== HOLD_CYC + 1) begin
        errors++; $display("FAIL single_ph%0d_latency: got %0d want %0d", ph, lat, HOLD_CYC + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd1 || rsp_quotient !== 32'd14 || rsp_reminder !== 32'd2) begin
      errors++; $display("FAIL single_hold_rsp: got v=%b id=%0d q=%0d r=%0d want v=0 id=1 q=14 r=2",
                         rsp_valid, rsp_id, rsp_quotient, rsp_reminder);
    end
    checks++;
    if (div_divident !== 32'd100 || div_divider !== 32'd7) begin
      errors++; $display("FAIL single_hold_ops: got %0d/%0d want 100/7", div_divident, div_divider);
    end
  endtask

  task automatic test_contention();
    bit ok;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < REQ; i++) set_ops(i, N'(i * 1000 + 5), N'(i + 2));
    req_valid = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    hs_q.delete();
    rsp_q.delete();
    model_grants('1);
    serve(REQ, REQ * (HOLD_CYC + 3) + 20, '0, ok);
    checks++;
    if (!ok || rsp_q.size() != REQ) begin
      errors++; $display("FAIL contention_count: got %0d want %0d responses", rsp_q.size(), REQ);
    end
    for (int k = 0; k < REQ && k < rsp_q.size(); k++) begin
      checks++;
      if (rsp_q[k].id !== exp_q[k] || rsp_q[k].quo !== ref_q(op_a[exp_q[k]], op_b[exp_q[k]]) ||
          rsp_q[k].rem !== ref_r(op_a[exp_q[k]], op_b[exp_q[k]])) begin
        errors++; $display("FAIL contention_rsp%0d: got id=%0d q=%0d r=%0d want id=%0d q=%0d r=%0d", k,
                           rsp_q[k].id, rsp_q[k].quo, rsp_q[k].rem, exp_q[k],
                           ref_q(op_a[exp_q[k]], op_b[exp_q[k]]), ref_r(op_a[exp_q[k]], op_b[exp_q[k]]));
      end
      if (k > 0) begin
        checks++;
        if (rsp_q[k].edge_n - rsp_q[k-1].edge_n !== HOLD_CYC + 3) begin
          errors++; $display("FAIL contention_gap%0d: got %0d want %0d", k,
                             rsp_q[k].edge_n - rsp_q[k-1].edge_n, HOLD_CYC + 3);
        end
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int want [3];
    want = '{0, 2, 0};
    hs_q.delete();
    rsp_q.delete();
    set_ops(0, $urandom, N'($urandom_range(1, 5000)));
    set_ops(2, $urandom, N'($urandom_range(1, 5000)));
    req_valid[0] = 1'b1;
    for (int c = 0; c < 20 && hs_q.size() == 0; c++) @(negedge clk);
    req_valid[2] = 1'b1;
    serve(3, 3 * (HOLD_CYC + 3) + 20, 4'b0001, ok);
    req_valid[0] = 1'b0;
    model_ptr = 1;
    checks++;
    if (!ok || hs_q.size() != 3) begin
      errors++; $display("FAIL fair_count: got %0d grants want 3", hs_q.size());
    end
    for (int k = 0; k < 3 && k < hs_q.size() && k < rsp_q.size(); k++) begin
      checks++;
      if (hs_q[k].id !== want[k] || rsp_q[k].id !== want[k] ||
          rsp_q[k].quo !== ref_q(op_a[want[k]], op_b[want[k]]) ||
          rsp_q[k].rem !== ref_r(op_a[want[k]], op_b[want[k]])) begin
        errors++; $display("FAIL fair_grant%0d: got gnt=%0d rsp=%0d q=%0d want id=%0d q=%0d", k,
                           hs_q[k].id, rsp_q[k].id, rsp_q[k].quo, want[k], ref_q(op_a[want[k]], op_b[want[k]]));
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [REQ-1:0] mask;
    logic [N-1:0] b;
    int e;
    for (int rd = 0; rd < 6; rd++) begin
      mask = REQ'($urandom_range(1, (1 << REQ) - 1));
      hs_q.delete();
      rsp_q.delete();
      for (int i = 0; i < REQ; i++) begin
        if (mask[i]) begin
          b = $urandom >> $urandom_range(0, N - 1);
          if (b == '0) b = 1;
          set_ops(i, $urandom, b);
        end
      end
      model_grants(mask);
      req_valid = mask;
      serve(exp_q.size(), exp_q.size() * (HOLD_CYC + 3) + 20, '0, ok);
      checks++;
      if (!ok || rsp_q.size() != exp_q.size() || hs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d rsp %0d gnt want %0d", rd, rsp_q.size(), hs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < rsp_q.size() && k < hs_q.size(); k++) begin
        e = exp_q[k];
        checks++;
        if (hs_q[k].id !== e || rsp_q[k].id !== e || rsp_q[k].quo !== ref_q(op_a[e], op_b[e]) ||
            rsp_q[k].rem !== ref_r(op_a[e], op_b[e]) || rsp_q[k].err !== 1'b0 ||
            rsp_q[k].edge_n - hs_q[k].edge_n !== HOLD_CYC + 1) begin
          errors++; $display("FAIL rand%0d_rsp%0d: got gnt=%0d id=%0d q=%h r=%h lat=%0d want id=%0d q=%h r=%h lat=%0d",
                             rd, k, hs_q[k].id, rsp_q[k].id, rsp_q[k].quo, rsp_q[k].rem,
                             rsp_q[k].edge_n - hs_q[k].edge_n, e, ref_q(op_a[e], op_b[e]),
                             ref_r(op_a[e], op_b[e]), HOLD_CYC + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    bit ok; rsp_t r; int lat;
    logic [N-1:0] a, b;
    hs_q.delete();
    rsp_q.delete();
    set_ops(3, $urandom, N'($urandom_range(1, 1000)));
    req_valid[3] = 1'b1;
    for (int c = 0; c < 20 && hs_q.size() == 0; c++) @(negedge clk);
    req_valid[3] = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, rsp_err, req_ready} !== '0) begin
      errors++; $display("FAIL midrst_ctrl: got %b want 0", {rsp_valid, busy, rsp_err, req_ready});
    end
    checks++;
    if ({div_divident, div_divider, rsp_id, rsp_quotient, rsp_reminder} !== '0) begin
      errors++; $display("FAIL midrst_data: got ops=%h/%h rsp=%0d/%h/%h want 0", div_divident, div_divider,
                         rsp_id, rsp_quotient, rsp_reminder);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    repeat (HOLD_CYC + 10) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0) begin
      errors++; $display("FAIL midrst_no_rsp: got %0d responses want 0", rsp_q.size());
    end
    a = $urandom;
    b = N'($urandom_range(1, 70000));
    run_one(2, a, b, ok, r, lat);
    checks++;
    if (!ok || r.id !== 2 || r.quo !== ref_q(a, b) || r.rem !== ref_r(a, b) || lat !== HOLD_CYC + 1) begin
      errors++; $display("FAIL midrst_after: got ok=%b id=%0d q=%h r=%h lat=%0d want id=2 q=%h r=%h lat=%0d",
                         ok, r.id, r.quo, r.rem, lat, ref_q(a, b), ref_r(a, b), HOLD_CYC + 1);
    end
    op_a[0] = a;
    op_b[0] = b;
  endtask

  task automatic test_zero();
    bit ok; rsp_t r; int lat;
    logic [N-1:0] prev_a, prev_b, want_a, want_b;
    logic want_err;
    int want_lat;
    prev_a = op_a[0];
    prev_b = op_b[0];
`ifdef DIV_SCHED_ZERO_CHECK_EN
    want_err = 1'b1; want_lat = 0;            want_a = prev_a; want_b = prev_b;
`else
    want_err = 1'b0; want_lat = HOLD_CYC + 1; want_a = 32'd55;  want_b = '0;
`endif
    @(negedge clk);
    run_one(0, 32'd55, 32'd0, ok, r, lat);
    checks++;
    if (!ok || r.id !== 0 || r.quo !== 32'hFFFF_FFFF || r.rem !== 32'd55 || r.err !== want_err) begin
      errors++; $display("FAIL zero_data: got ok=%b id=%0d q=%h r=%0d e=%b want id=0 q=ffffffff r=55 e=%b",
                         ok, r.id, r.quo, r.rem, r.err, want_err);
    end
    checks++;
    if (lat !== want_lat) begin
      errors++; $display("FAIL zero_latency: got %0d want %0d", lat, want_lat);
    end
    checks++;
    if (div_divident !== want_a || div_divider !== want_b) begin
      errors++; $display("FAIL zero_ops: got %h/%h want %h/%h", div_divident, div_divider, want_a, want_b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_random();
    test_reset_mid_hold();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
